// File: rtl/rect_fill_writer.sv
// Raster-order rectangle writer: FILL, XOR and INVERT modes over a pipelined pixel read port.
// Optional screen clipping is enabled by defining RECT_WRITER_CLIP_EN.
module rect_fill_writer #(
    parameter int X_WIDTH      = 9,
    parameter int Y_WIDTH      = 8,
    parameter int COLOUR_WIDTH = 3,
    parameter int SCREEN_W     = 320,
    parameter int SCREEN_H     = 240
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    output logic                    ready,
    input  logic [1:0]              mode,
    input  logic [COLOUR_WIDTH-1:0] colour,
    input  logic [X_WIDTH-1:0]      x_min,
    input  logic [X_WIDTH-1:0]      x_range,
    input  logic [Y_WIDTH-1:0]      y_min,
    input  logic [Y_WIDTH-1:0]      y_range,
    output logic                    rd_en,
    output logic [X_WIDTH-1:0]      rd_x,
    output logic [Y_WIDTH-1:0]      rd_y,
    input  logic [COLOUR_WIDTH-1:0] rd_colour,
    output logic                    plot,
    output logic [X_WIDTH-1:0]      wr_x,
    output logic [Y_WIDTH-1:0]      wr_y,
    output logic [COLOUR_WIDTH-1:0] wr_colour,
    output logic                    done
);

`ifdef RECT_WRITER_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t                  state;
    logic                    tail;
    logic [1:0]              mode_q;
    logic [COLOUR_WIDTH-1:0] colour_q;
    logic [X_WIDTH-1:0]      x_min_q, x_range_q, cx, px;
    logic [Y_WIDTH-1:0]      y_min_q, y_range_q, cy, py;
    logic                    is_rmw, visible;
    logic [COLOUR_WIDTH-1:0] rmw_colour;

    always_comb begin
        px         = x_min_q + cx;
        py         = y_min_q + cy;
        visible    = !CLIP || ((int'(px) < SCREEN_W) && (int'(py) < SCREEN_H));
        is_rmw     = (mode_q == 2'b01) || (mode_q == 2'b10);
        rmw_colour = (mode_q == 2'b01) ? (rd_colour ^ colour_q) : ~rd_colour;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            tail      <= 1'b0;
            ready     <= 1'b1;
            done      <= 1'b0;
            plot      <= 1'b0;
            rd_en     <= 1'b0;
            wr_x      <= '0;
            wr_y      <= '0;
            wr_colour <= '0;
            rd_x      <= '0;
            rd_y      <= '0;
            cx        <= '0;
            cy        <= '0;
            mode_q    <= '0;
            colour_q  <= '0;
            x_min_q   <= '0;
            x_range_q <= '0;
            y_min_q   <= '0;
            y_range_q <= '0;
        end else begin
            done  <= 1'b0;
            rd_en <= 1'b0;
            // Write stage of the RMW pipeline: last cycle's read becomes this cycle's write.
            plot  <= rd_en;
            if (rd_en) begin
                wr_x      <= rd_x;
                wr_y      <= rd_y;
                wr_colour <= rmw_colour;
            end

            case (state)
                S_IDLE: begin
                    if (start && ready) begin
                        mode_q    <= mode;
                        colour_q  <= colour;
                        x_min_q   <= x_min;
                        x_range_q <= x_range;
                        y_min_q   <= y_min;
                        y_range_q <= y_range;
                        cx        <= '0;
                        cy        <= '0;
                        tail      <= 1'b0;
                        ready     <= 1'b0;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!tail) begin
                        if (is_rmw) begin
                            rd_en <= visible;
                            rd_x  <= px;
                            rd_y  <= py;
                        end else begin
                            plot      <= visible;
                            wr_x      <= px;
                            wr_y      <= py;
                            wr_colour <= colour_q;
                        end
                        if (cx == x_range_q) begin
                            cx <= '0;
                            if (cy == y_range_q) tail <= 1'b1;
                            else                 cy   <= cy + 1'b1;
                        end else begin
                            cx <= cx + 1'b1;
                        end
                    end else begin
                        // One cycle after the last pixel: FILL completes, RMW still owes its last write.
                        tail <= 1'b0;
                        if (is_rmw) begin
                            state <= S_FLUSH;
                        end else begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                            ready <= 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                    ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
